// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_pkg
//  Brief    : Shared opcode constants, sequencer state type and control
//             encodings for the RV32I multi-cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // RV32I base opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // Next-PC source select
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JAL    = 2'd2;
    localparam logic [1:0] PC_SRC_JALR   = 2'd3;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // Trap cause codes
    localparam logic [1:0] TRAP_NONE        = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'd1;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'd2;

    // True for the nine base opcodes the sequencer knows how to walk
    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Brief    : Counts consecutive stalled cycles of a memory request and flags
//             a timeout on the last allowed cycle when ready is still low.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam int              CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0]   C_LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Count stalled cycles; any completed access or idle cycle restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (req_i && !ready_i) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // A ready arriving on the limit cycle wins, so ready masks the timeout
    assign timeout_o = req_i && !ready_i && (cnt_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/rv32i_mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_mc_sequencer
//  Brief    : Multi-cycle RV32I control FSM over a single shared memory port.
//             FETCH -> DECODE -> EXEC -> [MEM] -> WB, retire counting and a
//             sticky trap on illegal opcodes or memory timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_mc_sequencer
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             reg_write,
    input  logic             mem_to_reg,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             branch,
    input  logic             jump,
    input  logic             jalr,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trapped,
    output logic [1:0]       trap_cause
);

    state_e           state_q;
    logic             reg_write_q;
    logic             mem_to_reg_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic             branch_q;
    logic             jump_q;
    logic             jalr_q;
    logic             taken_q;
    logic [CNT_W-1:0] instret_q;
    logic             trapped_q;
    logic [1:0]       trap_cause_q;
    logic             mem_timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .req_i     (mem_req),
        .ready_i   (mem_ready),
        .timeout_o (mem_timeout)
    );

    // Strobe decode: request/address/write come from registered state only;
    // IR load and store retirement must fire in the mem_ready cycle itself
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_SEL_ALU;
        pc_we    = 1'b0;
        pc_src   = PC_SRC_PLUS4;
        retire   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = mem_write_q;
                if (mem_ready && mem_write_q) begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_PLUS4;
                    retire = 1'b1;
                end
            end
            ST_WB: begin
                rf_we  = reg_write_q;
                pc_we  = 1'b1;
                retire = 1'b1;
                if (jump_q || jalr_q) begin
                    wb_sel = WB_SEL_PC4;
                end else if (mem_to_reg_q) begin
                    wb_sel = WB_SEL_MEM;
                end
                if (jump_q) begin
                    pc_src = PC_SRC_JAL;
                end else if (jalr_q) begin
                    pc_src = PC_SRC_JALR;
                end else if (branch_q && taken_q) begin
                    pc_src = PC_SRC_BRANCH;
                end
            end
            default: ;
        endcase
    end

    // Instruction sequencing, flag latching, retire counting and trap capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            jalr_q       <= 1'b0;
            taken_q      <= 1'b0;
            instret_q    <= '0;
            trapped_q    <= 1'b0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_q <= ST_DECODE;
                    end else if (mem_timeout) begin
                        state_q      <= ST_TRAP;
                        trapped_q    <= 1'b1;
                        trap_cause_q <= TRAP_MEM_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    reg_write_q  <= reg_write;
                    mem_to_reg_q <= mem_to_reg;
                    mem_read_q   <= mem_read;
                    mem_write_q  <= mem_write;
                    branch_q     <= branch;
                    jump_q       <= jump;
                    jalr_q       <= jalr;
                    if (!is_legal_opcode(opcode)) begin
                        state_q      <= ST_TRAP;
                        trapped_q    <= 1'b1;
                        trap_cause_q <= TRAP_ILLEGAL;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    taken_q <= branch_q && branch_taken;
                    state_q <= (mem_read_q || mem_write_q) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (mem_write_q) begin
                            state_q <= run ? ST_FETCH : ST_IDLE;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end else if (mem_timeout) begin
                        state_q      <= ST_TRAP;
                        trapped_q    <= 1'b1;
                        trap_cause_q <= TRAP_MEM_TIMEOUT;
                    end
                end
                ST_WB: begin
                    state_q <= run ? ST_FETCH : ST_IDLE;
                end
                ST_TRAP: begin
                    state_q <= ST_TRAP;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign instret    = instret_q;
    assign trapped    = trapped_q;
    assign trap_cause = trap_cause_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_mc_sequencer
//  Brief    : Scoreboard bench for rv32i_mc_sequencer: random instruction
//             stream with random memory waits, plus trap and reset scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_mc_sequencer;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

    logic        clk = 1'b0;
    logic        rst, run;
    logic [6:0]  opcode;
    logic        reg_write, mem_to_reg, mem_read, mem_write, branch, jump, jalr;
    logic        branch_taken, mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_we, rf_we, pc_we, retire, trapped;
    logic [1:0]  wb_sel, pc_src, trap_cause;
    logic [31:0] instret;

    rv32i_mc_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .jump(jump), .jalr(jalr),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
        .retire(retire), .instret(instret), .trapped(trapped), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] lat;
        logic       rf;
        logic [1:0] wb;
        logic [1:0] pc;
        logic       store;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int unsigned model_cnt = 0;
    int unsigned issued    = 0;
    int          mon_cyc   = 0;
    bit          mon_busy  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Reference: what each instruction class must produce when it retires
    function automatic exp_t model(input int k, input bit taken, input int fw, input int mw);
        exp_t e;
        bit   is_mem;
        e.store = (k == K_STORE);
        is_mem  = (k == K_LOAD) || (k == K_STORE);
        e.rf    = !(k == K_STORE || k == K_BR);
        e.wb    = (k == K_JAL || k == K_JALR) ? 2'd2 : (k == K_LOAD) ? 2'd1 : 2'd0;
        e.pc    = (k == K_JAL) ? 2'd2 : (k == K_JALR) ? 2'd3 : (k == K_BR && taken) ? 2'd1 : 2'd0;
        e.lat   = 8'((fw + 1) + 2 + (is_mem ? (mw + 1) : 0) + (e.store ? 0 : 1));
        return e;
    endfunction

    // Decoder stand-in: opcode and flags for an instruction class
    task automatic apply_kind(input int k);
        {reg_write, mem_to_reg, mem_read, mem_write, branch, jump, jalr} = '0;
        case (k)
            K_R:     begin opcode = 7'b0110011; reg_write = 1; end
            K_I:     begin opcode = 7'b0010011; reg_write = 1; end
            K_LOAD:  begin opcode = 7'b0000011; reg_write = 1; mem_to_reg = 1; mem_read = 1; end
            K_STORE: begin opcode = 7'b0100011; mem_write = 1; end
            K_BR:    begin opcode = 7'b1100011; branch = 1; end
            K_JAL:   begin opcode = 7'b1101111; jump = 1; reg_write = 1; end
            K_JALR:  begin opcode = 7'b1100111; jalr = 1; reg_write = 1; end
            K_LUI:   begin opcode = 7'b0110111; reg_write = 1; end
            default: begin opcode = 7'b0010111; reg_write = 1; end
        endcase
    endtask

    task automatic scramble_flags();
        opcode = 7'($urandom);
        {reg_write, mem_to_reg, mem_read, mem_write, branch, jump, jalr} = 7'($urandom);
    endtask

    function automatic bit legal_op(input logic [6:0] op);
        logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        foreach (legal[i]) if (legal[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one instruction to retirement, acting as memory with given waits
    task automatic do_instr(input int k, input int fw, input int mw, input bit taken, input bit drop_run);
        int fwc   = fw;
        int mwc   = mw;
        int after = -1;
        int guard = 0;
        bit done  = 0;
        apply_kind(k);
        branch_taken = taken;
        sb_q.push_back(model(k, taken, fw, mw));
        issued++;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
            if (after >= 0) after++;
            if (after == 2) begin
                scramble_flags();
                if (drop_run) run = 1'b0;
            end
            if (after >= 3) branch_taken = 1'($urandom);
            if (mem_req && !addr_sel) begin
                if (fwc == 0) mem_ready = 1'b1; else begin mem_ready = 1'b0; fwc--; end
            end else if (mem_req && addr_sel) begin
                if (mwc == 0) mem_ready = 1'b1; else begin mem_ready = 1'b0; mwc--; end
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            if (ir_we && after < 0) after = 0;
            if (retire) done = 1;
        end
        if (!done) fail_now("instr_no_retire");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: per-cycle strobe rules and scoreboard comparison at retirement
    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb_q.delete();
            mon_busy  = 0;
            model_cnt = 0;
        end else begin
            if (mem_req && !addr_sel && !mon_busy) begin
                mon_busy = 1;
                mon_cyc  = 0;
            end
            if (mon_busy) mon_cyc++;
            if (trapped)
                check("trap_strobes", {31'd0, mem_req | ir_we | rf_we | pc_we | retire | mem_we}, 32'd0);
            check("ir_we", {31'd0, ir_we}, {31'd0, mem_req && !addr_sel && mem_ready});
            check("pc_we_vs_retire", {31'd0, pc_we}, {31'd0, retire});
            if (!retire) check("rf_we_outside_wb", {31'd0, rf_we}, 32'd0);
            if (mem_req && !addr_sel) check("fetch_mem_we", {31'd0, mem_we}, 32'd0);
            if (mem_req && addr_sel) begin
                if (sb_q.size() == 0) fail_now("mem_access_unexpected");
                else check("mem_we", {31'd0, mem_we}, {31'd0, sb_q[0].store});
            end
            if (retire) begin
                if (sb_q.size() == 0) begin
                    fail_now("retire_unexpected");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rf_we", {31'd0, rf_we}, {31'd0, mon_e.rf});
                    check("pc_src", {30'd0, pc_src}, {30'd0, mon_e.pc});
                    if (!mon_e.store) check("wb_sel", {30'd0, wb_sel}, {30'd0, mon_e.wb});
                    check("latency", mon_cyc, {24'd0, mon_e.lat});
                    check("instret_at_retire", instret, model_cnt);
                    model_cnt++;
                end
                mon_busy = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int k, fw, mw;
        logic [6:0] bad;
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        apply_kind(K_R);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_trapped", {31'd0, trapped}, 32'd0);
        check("rst_trap_cause", {30'd0, trap_cause}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;

        // Directed classes
        do_instr(K_R, 0, 0, 0, 0);
        do_instr(K_LOAD, 0, 3, 0, 0);
        do_instr(K_STORE, 0, 0, 0, 0);
        do_instr(K_BR, 0, 0, 1, 0);
        do_instr(K_BR, 0, 0, 0, 0);
        do_instr(K_JALR, 0, 0, 0, 0);
        do_instr(K_JAL, 2, 0, 0, 0);
        do_instr(K_LOAD, 15, 15, 0, 0);

        // Random stream, occasional run drop parks the FSM in IDLE
        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 8);
            fw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
            do_instr(k, fw, mw, 1'($urandom), $urandom_range(0, 7) == 0);
            if (!run) begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    mem_ready = 1'($urandom);
                    #1;
                    check("parked_mem_req", {31'd0, mem_req}, 32'd0);
                end
                @(negedge clk);
                run = 1'b1;
            end
        end
        @(negedge clk);
        #3;
        check("instret_total", instret, issued);

        // Reset during MEM of a load: access dropped, counter cleared
        do_reset();
        run = 1'b1;
        apply_kind(K_LOAD);
        sb_q.push_back(model(K_LOAD, 0, 0, 20));
        cnt = 0;
        while (!(mem_req && addr_sel) && cnt < 20) begin
            @(negedge clk);
            cnt++;
            mem_ready = mem_req && !addr_sel;
            #1;
        end
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0; run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_instret", instret, 32'd0);
        check("rst_mid_retire", {31'd0, retire}, 32'd0);

        // Illegal opcodes trap with cause 1
        for (int t = 0; t < 3; t++) begin
            do_reset();
            if (t == 0) bad = 7'h7F;
            else begin
                bad = 7'($urandom);
                while (legal_op(bad)) bad = 7'($urandom);
            end
            opcode = bad;
            {reg_write, mem_to_reg, mem_read, mem_write, branch, jump, jalr} = 7'($urandom);
            run = 1'b1;
            mem_ready = 1'b1;
            cnt = 0;
            while (!trapped && cnt < 10) begin
                @(negedge clk);
                cnt++;
                #1;
            end
            check("illegal_trapped", {31'd0, trapped}, 32'd1);
            check("illegal_cause", {30'd0, trap_cause}, 32'd1);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                #1;
                check("trap_mem_req", {31'd0, mem_req}, 32'd0);
            end
            check("illegal_instret", instret, 32'd0);
        end

        // Fetch never answered: 16 request cycles then timeout trap
        do_reset();
        apply_kind(K_R);
        run = 1'b1;
        mem_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && !trapped; i++) begin
            @(negedge clk);
            #1;
            if (mem_req) cnt++;
        end
        check("fetch_timeout_cycles", cnt, 32'd16);
        check("fetch_timeout_cause", {30'd0, trap_cause}, 32'd2);
        check("fetch_timeout_trapped", {31'd0, trapped}, 32'd1);

        // Store never answered in MEM: timeout trap, no retirement
        do_reset();
        apply_kind(K_STORE);
        sb_q.push_back(model(K_STORE, 0, 0, 20));
        run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60 && !trapped; i++) begin
            @(negedge clk);
            mem_ready = mem_req && !addr_sel;
            #1;
            if (mem_req && addr_sel) cnt++;
        end
        check("mem_timeout_cycles", cnt, 32'd16);
        check("mem_timeout_cause", {30'd0, trap_cause}, 32'd2);
        check("mem_timeout_instret", instret, 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_mc_sequencer.md
Name: rv32i_mc_sequencer

Overview:
- Multi-cycle control FSM that sequences the RV32I datapath around the instruction decoder, over a single shared memory port used for both instruction fetch and load/store.
- Walks each instruction through FETCH → DECODE → EXEC → [MEM] → WB.
- Generates register-file, PC, IR and memory strobes from the decoder's control flags.
- Counts retired instructions, detects illegal opcodes and memory timeouts, and enters a sticky trap.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles `mem_req` may wait for `mem_ready` before a timeout trap.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- run  in  1  permission to start a new fetch
- opcode  in  7  opcode field of the current IR, from the decoder
- reg_write, mem_to_reg, mem_read, mem_write, branch, jump, jalr  in  1 each  decoder control flags
- branch_taken  in  1  comparator result, valid in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe for the current access
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- rf_we  out  1  register-file write enable
- wb_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4
- pc_we  out  1  PC update enable
- pc_src  out  2  next PC: 0 = PC+4, 1 = branch target, 2 = jal target, 3 = jalr target
- retire  out  1  one-cycle pulse per retired instruction
- instret  out  CNT_W  retired-instruction count
- trapped  out  1  sticky trap flag
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout

Behaviour:
- Reset: one clock, synchronous, active-high (`rst`), sampled on the rising edge of `clk`.
  - State goes to IDLE.
  - `instret` = 0, `trapped` = 0, `trap_cause` = 0, wait counter = 0, latched flags = 0.
  - All strobes are 0 in IDLE.
  - Reset asserted mid-access drops `mem_req` on the following cycle; no write-back or PC update occurs.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding is 3 bits.
- IDLE: go to FETCH when `run` = 1.
- FETCH:
  - Drive `mem_req` = 1, `addr_sel` = 0, `mem_we` = 0.
  - When `mem_ready` = 1: `ir_we` = 1 in that same cycle, then go to DECODE.
- DECODE (1 cycle):
  - Latch all decoder flags into registers; EXEC/MEM/WB use only the latched copies.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode: go to TRAP with `trap_cause` = 1. Otherwise go to EXEC.
- EXEC (1 cycle): if `mem_read` or `mem_write` go to MEM, else go to WB. If branch, register `branch_taken` for use in WB.
- MEM:
  - Drive `mem_req` = 1, `addr_sel` = 1, `mem_we` = latched `mem_write`.
  - When `mem_ready` = 1:
    - Load: go to WB.
    - Store: in the same cycle assert `pc_we` = 1, `pc_src` = 0 and `retire` = 1, then go to FETCH (or IDLE if `run` = 0).
- WB (1 cycle):
  - `rf_we` = latched `reg_write`.
  - `wb_sel`: 2 if jump or jalr; 1 if `mem_to_reg`; otherwise 0.
  - `pc_we` = 1.
  - `pc_src`: 2 if jump; 3 if jalr; 1 if branch and taken; otherwise 0.
  - `retire` = 1. Next state is FETCH if `run` = 1, else IDLE.
- `run` is sampled only at instruction boundaries (IDLE and retirement). Deasserting it mid-instruction does not abort that instruction.
- Timeout:
  - The wait counter increments each cycle `mem_req` = 1 and `mem_ready` = 0, and clears on `mem_ready` or on a state change.
  - When the count reaches MEM_TIMEOUT−1 with `mem_ready` still 0, go to TRAP with `trap_cause` = 2.
  - If `mem_ready` arrives in that same cycle, `mem_ready` wins and the access completes.
- TRAP: all strobes 0, `trapped` = 1. Leaves only on `rst`.
- `instret` increments on each `retire` and wraps modulo 2^CNT_W.
- Latency in cycles, with zero-wait memory:
  - ALU, branch, jal, jalr, lui, auipc: 4
  - load: 5
  - store: 4
  - Each memory wait cycle adds 1.
- `mem_req`, `mem_we`, `addr_sel` depend on the state register only. `ir_we` and the store-path `pc_we`/`retire` are qualified by `mem_ready`.

Decomposition:
- Shared package `rv32i_pkg`:
  - Opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - State enum.
  - pc_src and wb_sel encodings.
  - trap_cause codes.
- One sub-module, `mem_wait_timer`: wait counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset then `run` = 1, opcode 0110011, `reg_write` = 1, `mem_ready` always 1 → `ir_we` in cycle 1, `rf_we` = 1 and `wb_sel` = 0 in cycle 4, `retire` pulse, `instret` = 1.
- Load with opcode 0000011 and `mem_ready` delayed 3 cycles in MEM → `rf_we` = 1 and `wb_sel` = 1 at cycle 8; `mem_req` held continuously with `addr_sel` = 1.
- Store with opcode 0100011 → `mem_we` = 1 during MEM; `retire` and `pc_we` with `pc_src` = 0 on the `mem_ready` cycle; `rf_we` never asserted.
- Branch with `branch_taken` = 1 → `pc_src` = 1; with 0 → `pc_src` = 0. jalr → `pc_src` = 3, `wb_sel` = 2, `rf_we` = 1.
- Opcode 1111111 → TRAP, `trap_cause` = 1, `mem_req` stays 0. `mem_ready` held at 0 in FETCH for 16 cycles → `trap_cause` = 2.
- `rst` asserted during MEM; `run` dropped during EXEC → after reset, state is IDLE and `instret` = 0; with `run` low, the current instruction retires and the FSM parks in IDLE.
